// File: rtl/mmio_uart_pkg.sv
// Shared register map, STATUS/CTRL bit positions and transmit FSM encoding
// for the memory-mapped UART transmitter.
package mmio_uart_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 4;
  localparam int ST_COUNT_W   = 7;

  localparam int CTRL_IE = 0;
  localparam int CTRL_EN = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through head, occupancy count and
// full/empty flags. Push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [WIDTH-1:0]   i_data,
  output logic [WIDTH-1:0]   o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic               o_full,
  output logic               o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // NOTE: storage is not reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/CTRL register window
// feeding a transmit FIFO drained by a start/data/stop bit FSM.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic [31:0] memreaddata,
  output logic        hit,
  output logic        txd,
  output logic        irq
);

  localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  tx_state_e   r_state;
  tx_state_e   w_state_next;
  logic [15:0] r_bit_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_ovf;
  logic        r_ie;
  logic        r_en;

  logic [1:0]    w_offset;
  logic          w_wr;
  logic          w_wr_tx;
  logic          w_push;
  logic          w_pop;
  logic          w_ovf_set;
  logic          w_ovf_clr;
  logic          w_bit_done;
  logic          w_full;
  logic          w_empty;
  logic [7:0]    w_head;
  logic [CW-1:0] w_count;
  logic [31:0]   w_status;
  logic          w_unused;

  assign hit       = (memaddr[31:4] == BASE_ADDR[31:4]);
  assign w_offset  = memaddr[3:2];
  assign w_wr      = hit & memwrite;
  assign w_wr_tx   = w_wr && (w_offset == OFF_TXDATA);
  // Fullness is the pre-edge value, so a same-edge pop never rescues a push.
  assign w_push    = w_wr_tx & ~w_full;
  assign w_ovf_set = w_wr_tx & w_full;
  assign w_ovf_clr = w_wr && (w_offset == OFF_STATUS) && memwritedata[ST_OVF];
  assign w_unused  = &{1'b0, memaddr[1:0], memwritedata[31:8]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (memwritedata[7:0]),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_ie  <= 1'b0;
      r_en  <= 1'b1;
    end else begin
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
      if (w_wr && (w_offset == OFF_CTRL)) begin
        r_ie <= memwritedata[CTRL_IE];
        r_en <= memwritedata[CTRL_EN];
      end
    end
  end

  assign w_bit_done = (r_bit_cnt == BIT_LAST);

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: if (r_en && !w_empty) begin
        w_pop        = 1'b1;
        w_state_next = S_START;
      end
      S_START: if (w_bit_done) w_state_next = S_DATA;
      S_DATA:  if (w_bit_done && (r_bit_idx == 3'd7)) w_state_next = S_STOP;
      S_STOP: if (w_bit_done) begin
        if (r_en && !w_empty) begin
          w_pop        = 1'b1;
          w_state_next = S_START;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_pop) begin
        r_shift   <= w_head;
        r_bit_cnt <= '0;
      end else if (r_state != S_IDLE) begin
        r_bit_cnt <= w_bit_done ? 16'd0 : r_bit_cnt + 16'd1;
      end
      if ((r_state == S_DATA) && w_bit_done) begin
        r_shift   <= r_shift >> 1;
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

  always_comb begin
    case (r_state)
      S_START: txd = 1'b0;
      S_DATA:  txd = r_shift[0];
      default: txd = 1'b1;
    endcase
  end

  assign irq = w_empty & (r_state == S_IDLE) & r_ie;

  always_comb begin
    w_status                                = '0;
    w_status[ST_FULL]                       = w_full;
    w_status[ST_EMPTY]                      = w_empty;
    w_status[ST_BUSY]                       = (r_state != S_IDLE);
    w_status[ST_OVF]                        = r_ovf;
    w_status[ST_COUNT_LSB +: ST_COUNT_W]    = ST_COUNT_W'(w_count);
  end

  always_comb begin
    memreaddata = '0;
    if (hit) begin
      case (w_offset)
        OFF_STATUS: memreaddata = w_status;
        OFF_CTRL: begin
          memreaddata[CTRL_IE] = r_ie;
          memreaddata[CTRL_EN] = r_en;
        end
        OFF_TXDATA, OFF_RSVD: memreaddata = '0;
        default: memreaddata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register map, frame timing, FIFO overflow,
// back-to-back frames, irq behaviour and mid-frame reset.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'hFFFF0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic [31:0] memreaddata;
  logic        hit;
  logic        txd;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (16),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .memwrite     (memwrite),
    .memaddr      (memaddr),
    .memwritedata (memwritedata),
    .memreaddata  (memreaddata),
    .hit          (hit),
    .txd          (txd),
    .irq          (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; the write is sampled at the next rising edge and
  // the task returns at the following falling edge, so calls chain edge by edge.
  task automatic bus_write(input logic [1:0] off, input logic [31:0] data);
    memaddr      = BASE + {28'd0, off, 2'b00};
    memwritedata = data;
    memwrite     = 1'b1;
    @(negedge clk);
    memwrite     = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    memaddr = addr;
    #1;
    data = memreaddata;
  endtask

  task automatic check_status(input string tag, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(BASE + 32'h4, d);
    check(tag, d, exp);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    memwrite = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic rx_byte(output logic [7:0] b, output int start_cyc);
    logic found;
    found     = 1'b0;
    b         = '0;
    start_cyc = 0;
    for (int i = 0; i < 400; i++) begin
      if (txd === 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rx_start_found", {31'd0, found}, 32'd1);
    if (found) begin
      start_cyc = cyc;
      repeat (8) @(negedge clk);
      check("rx_start_mid", {31'd0, txd}, 32'd0);
      for (int j = 0; j < 8; j++) begin
        repeat (16) @(negedge clk);
        b[j] = txd;
      end
      repeat (16) @(negedge clk);
      check("rx_stop_mid", {31'd0, txd}, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [9:0]  frame;
    logic [7:0]  rb;
    int          t0;
    int          t1;

    reset        = 1'b1;
    memwrite     = 1'b0;
    memaddr      = '0;
    memwritedata = '0;
    @(negedge clk);
    do_reset();

    // Reset state
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check_status("rst_status", 32'h002);
    bus_read(BASE + 32'h8, d);
    check("rst_ctrl", d, 32'h2);

    // Single frame 0xA5: start, LSB-first data, stop; 16 cycles per bit
    bus_write(2'd0, 32'hA5);
    check("a5_txd_before", {31'd0, txd}, 32'd1);
    check_status("a5_status_queued", 32'h010);
    @(negedge clk);
    check_status("a5_status_busy", 32'h006);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 10; i++) begin
      check($sformatf("a5_bit%0d_first", i), {31'd0, txd}, {31'd0, frame[i]});
      repeat (15) @(negedge clk);
      check($sformatf("a5_bit%0d_last", i), {31'd0, txd}, {31'd0, frame[i]});
      @(negedge clk);
    end
    check_status("a5_idle_after_160", 32'h002);
    check("a5_txd_idle", {31'd0, txd}, 32'd1);

    // EN=0: nine writes fill eight entries and overflow once
    bus_write(2'd2, 32'h0);
    for (int i = 0; i < 9; i++) bus_write(2'd0, 32'(i));
    check_status("fill_full_ovf", 32'h089);
    check("fill_txd_quiet", {31'd0, txd}, 32'd1);
    bus_write(2'd1, 32'h8);
    check_status("fill_ovf_cleared", 32'h081);
    bus_write(2'd2, 32'h2);
    for (int i = 0; i < 8; i++) begin
      rx_byte(rb, t1);
      check($sformatf("fill_rx%0d", i), {24'd0, rb}, 32'(i));
    end
    repeat (40) @(negedge clk);
    check_status("fill_drained", 32'h002);
    check("fill_no_ninth", {31'd0, txd}, 32'd1);

    // Push to a full FIFO on the same edge as a pop is dropped
    bus_write(2'd2, 32'h0);
    for (int i = 0; i < 8; i++) bus_write(2'd0, 32'h40 + 32'(i));
    check_status("pp_full", 32'h081);
    bus_write(2'd2, 32'h2);
    bus_write(2'd0, 32'h77);
    check_status("pp_dropped", 32'h07C);
    do_reset();
    check_status("pp_reset", 32'h002);

    // Back-to-back frames, 160 cycles apart
    bus_write(2'd0, 32'h3C);
    bus_write(2'd0, 32'hC3);
    rx_byte(rb, t0);
    check("b2b_rx0", {24'd0, rb}, 32'h3C);
    rx_byte(rb, t1);
    check("b2b_rx1", {24'd0, rb}, 32'hC3);
    check("b2b_spacing", 32'(t1 - t0), 32'd160);
    repeat (40) @(negedge clk);

    // irq, OVF clear and address decode
    do_reset();
    bus_write(2'd2, 32'h3);
    check("irq_idle_empty", {31'd0, irq}, 32'd1);
    bus_write(2'd0, 32'h5A);
    check("irq_queued", {31'd0, irq}, 32'd0);
    repeat (160) @(negedge clk);
    check("irq_stop_last", {31'd0, irq}, 32'd0);
    check_status("irq_busy_last", 32'h006);
    @(negedge clk);
    check("irq_after_stop", {31'd0, irq}, 32'd1);
    check_status("irq_idle", 32'h002);
    bus_write(2'd2, 32'h1);
    for (int i = 0; i < 9; i++) bus_write(2'd0, 32'h11 * 32'(i));
    check_status("ovf_set", 32'h089);
    check("irq_nonempty", {31'd0, irq}, 32'd0);
    bus_write(2'd1, 32'h0);
    check_status("ovf_kept", 32'h089);
    bus_write(2'd1, 32'h8);
    check_status("ovf_clr", 32'h081);
    bus_read(32'h0000_1004, d);
    check("miss_data", d, 32'h0);
    check("miss_hit", {31'd0, hit}, 32'd0);
    bus_read(BASE + 32'h10, d);
    check("next_window_hit", {31'd0, hit}, 32'd0);
    check("next_window_data", d, 32'h0);
    bus_read(BASE + 32'hB, d);
    check("ctrl_lowbits", d, 32'h1);
    check("ctrl_hit", {31'd0, hit}, 32'd1);
    bus_read(BASE + 32'hC, d);
    check("rsvd_read", d, 32'h0);
    bus_read(BASE, d);
    check("txdata_read", d, 32'h0);

    // Reset during data bit 3 aborts the frame at once
    do_reset();
    bus_write(2'd0, 32'h00);
    repeat (69) @(negedge clk);
    check("mid_txd_low", {31'd0, txd}, 32'd0);
    check_status("mid_busy", 32'h006);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_txd", {31'd0, txd}, 32'd1);
    check_status("mid_rst_status", 32'h002);
    check("mid_rst_irq", {31'd0, irq}, 32'd0);
    repeat (20) @(negedge clk);
    check("mid_rst_quiet", {31'd0, txd}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
